// File: rtl/ascon_perm_sequencer.sv
// Upstream sequencer for the bit-serial ASCON round core: load, round/constant drive, unload, output handshake.
// Optional round-timeout watchdog (adds wd_err port) enabled by defining ASCON_SEQ_WATCHDOG_EN.
module ascon_perm_sequencer #(
    parameter int unsigned LANE_BITS = 64,
    parameter int unsigned ROUNDS_A  = 12,
    parameter int unsigned ROUNDS_B  = 6,
    parameter int unsigned WD_CYCLES = 256
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [5*LANE_BITS-1:0] state_in,
    input  logic                   rounds_sel,
    output logic [0:4]             perm_data,
    output logic                   perm_load,
    output logic                   perm_start,
    output logic                   perm_const,
    input  logic                   round_done,
    input  logic [0:4]             perm_out,
    output logic                   perm_unload,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [5*LANE_BITS-1:0] state_out
`ifdef ASCON_SEQ_WATCHDOG_EN
    ,
    output logic                   wd_err
`endif
);

    localparam int unsigned BW = $clog2(LANE_BITS);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LOAD   = 3'd1,
        S_START  = 3'd2,
        S_WAIT   = 3'd3,
        S_UNLOAD = 3'd4,
        S_DONE   = 3'd5
    } state_t;

    state_t state, state_nx;

    logic [LANE_BITS-1:0] lane [5];
    logic [3:0]           round;
    logic [3:0]           nrounds;
    logic [3:0]           i0;
    logic [3:0]           rc_i;
    logic [7:0]           rc;
    logic [2:0]           rc_pos;
    logic [BW-1:0]        b;
    logic                 last_bit;
    logic                 last_round;
    logic                 wd_fire;

    assign last_bit   = (b == BW'(LANE_BITS - 1));
    assign last_round = (round == nrounds - 4'd1);
    assign rc_i       = i0 + round;
    assign rc         = {4'hF - rc_i, rc_i};
    // LANE_BITS is a power of two, so LANE_BITS-1-b reduces to ~b in the low bits
    assign rc_pos     = ~b[2:0];

`ifdef ASCON_SEQ_WATCHDOG_EN
    logic [8:0] wd_cnt;

    assign wd_fire = (state == S_WAIT) && !round_done && (wd_cnt == 9'(WD_CYCLES - 1));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wd_cnt <= '0;
            wd_err <= 1'b0;
        end else begin
            wd_err <= wd_fire;
            if (state == S_WAIT) begin
                wd_cnt <= wd_cnt + 9'd1;
            end else begin
                wd_cnt <= '0;
            end
        end
    end
`else
    assign wd_fire = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx    = state;
        in_ready    = 1'b0;
        perm_load   = 1'b0;
        perm_start  = 1'b0;
        perm_const  = 1'b0;
        perm_unload = 1'b0;
        out_valid   = 1'b0;
        perm_data   = '0;
        case (state)
            S_IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    state_nx = S_LOAD;
                end
            end
            S_LOAD: begin
                perm_load = 1'b1;
                for (int unsigned k = 0; k < 5; k++) begin
                    perm_data[k] = lane[k][LANE_BITS-1];
                end
                if (last_bit) begin
                    state_nx = S_START;
                end
            end
            S_START: begin
                perm_start = 1'b1;
                state_nx   = S_WAIT;
            end
            S_WAIT: begin
                perm_const = (b >= BW'(LANE_BITS - 8)) ? rc[rc_pos] : 1'b0;
                if (round_done) begin
                    state_nx = last_round ? S_UNLOAD : S_START;
                end else if (wd_fire) begin
                    state_nx = S_IDLE;
                end
            end
            S_UNLOAD: begin
                perm_unload = 1'b1;
                if (last_bit) begin
                    state_nx = S_DONE;
                end
            end
            S_DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_nx = S_IDLE;
                end
            end
            default: begin
                state_nx = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int unsigned k = 0; k < 5; k++) begin
                lane[k] <= '0;
            end
            nrounds <= '0;
            i0      <= '0;
            round   <= '0;
            b       <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (in_valid) begin
                        for (int unsigned k = 0; k < 5; k++) begin
                            lane[k] <= state_in[(4-k)*LANE_BITS +: LANE_BITS];
                        end
                        nrounds <= rounds_sel ? 4'(ROUNDS_B) : 4'(ROUNDS_A);
                        i0      <= rounds_sel ? 4'(12 - ROUNDS_B) : 4'(12 - ROUNDS_A);
                        round   <= '0;
                        b       <= '0;
                    end
                end
                S_LOAD: begin
                    for (int unsigned k = 0; k < 5; k++) begin
                        lane[k] <= {lane[k][LANE_BITS-2:0], 1'b0};
                    end
                    b <= last_bit ? '0 : b + 1'b1;
                end
                S_START: begin
                    b <= '0;
                end
                S_WAIT: begin
                    if (!last_bit) begin
                        b <= b + 1'b1;
                    end
                    if (round_done) begin
                        round <= round + 4'd1;
                        if (last_round) begin
                            b <= '0;
                        end
                    end
                end
                S_UNLOAD: begin
                    for (int unsigned k = 0; k < 5; k++) begin
                        lane[k] <= {lane[k][LANE_BITS-2:0], perm_out[k]};
                    end
                    b <= last_bit ? '0 : b + 1'b1;
                end
                default: begin
                end
            endcase
        end
    end

    always_comb begin
        state_out = '0;
        for (int unsigned k = 0; k < 5; k++) begin
            state_out[(4-k)*LANE_BITS +: LANE_BITS] = lane[k];
        end
    end

endmodule

// File: tb/tb_ascon_perm_sequencer.sv
// Directed bench for ascon_perm_sequencer with a behavioural serial round-core model.
module tb_ascon_perm_sequencer;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [319:0] state_in = '0;
    logic         rounds_sel = 1'b0;
    logic [0:4]   perm_data;
    logic         perm_load, perm_start, perm_const;
    logic         round_done = 1'b0;
    logic [0:4]   perm_out = '0;
    logic         perm_unload, out_valid;
    logic         out_ready = 1'b0;
    logic [319:0] state_out;
`ifdef ASCON_SEQ_WATCHDOG_EN
    logic         wd_err;
`endif

    ascon_perm_sequencer #(
        .LANE_BITS(64),
        .ROUNDS_A (12),
        .ROUNDS_B (6),
        .WD_CYCLES(256)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .state_in   (state_in),
        .rounds_sel (rounds_sel),
        .perm_data  (perm_data),
        .perm_load  (perm_load),
        .perm_start (perm_start),
        .perm_const (perm_const),
        .round_done (round_done),
        .perm_out   (perm_out),
        .perm_unload(perm_unload),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .state_out  (state_out)
`ifdef ASCON_SEQ_WATCHDOG_EN
        ,
        .wd_err     (wd_err)
`endif
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    int cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    localparam logic [319:0] R1 = {64'h0123_4567_89AB_CDEF, 64'hFEDC_BA98_7654_3210,
                                   64'hDEAD_BEEF_0000_0001, 64'h8000_0000_0000_0000,
                                   64'h0000_0000_CAFE_F00D};
    localparam logic [319:0] R2 = {64'h1111_2222_3333_4444, 64'h0000_0000_0000_0001,
                                   64'hA5A5_5A5A_F0F0_0F0F, 64'hFFFF_FFFF_FFFF_FFFF,
                                   64'h8000_0000_0000_0001};

    // Serial round-core model: round_done core_lat cycles after perm_start,
    // unload streams core_shift lanes MSB first; also monitors load and constants.
    int           core_lat = 70;
    bit           core_en = 1'b1;
    bit           core_active = 1'b0;
    int           core_cnt = 0;
    logic [319:0] core_shift = '0;
    int           start_cnt = 0;
    int           load_cnt = 0;
    int           unload_cnt = 0;
    logic [7:0]   cap = '0;
    logic [7:0]   consts [16];
    logic [63:0]  load_cap [5];

    always @(negedge clk) begin
        if (!rst) begin
            core_active = 1'b0;
            round_done  = 1'b0;
            perm_out    = '0;
        end else begin
            if (perm_start) begin
                core_active = 1'b1;
                core_cnt    = 0;
                start_cnt++;
                cap = '0;
            end else if (core_active && core_cnt < 1000) begin
                core_cnt++;
            end
            if (core_active && core_cnt >= 57 && core_cnt <= 64) begin
                cap = {cap[6:0], perm_const};
                if (core_cnt == 64 && start_cnt >= 1 && start_cnt <= 16) consts[start_cnt-1] = cap;
            end
            round_done = core_active && core_en && (core_cnt == core_lat);
            if (perm_load) begin
                load_cnt++;
                for (int k = 0; k < 5; k++) load_cap[k] = {load_cap[k][62:0], perm_data[k]};
            end
            if (perm_unload) begin
                unload_cnt++;
                for (int k = 0; k < 5; k++) begin
                    perm_out[k] = core_shift[(4-k)*64 + 63];
                    core_shift[(4-k)*64 +: 64] = {core_shift[(4-k)*64 +: 63], 1'b0};
                end
            end
        end
    end

    task automatic clear_mon();
        start_cnt  = 0;
        load_cnt   = 0;
        unload_cnt = 0;
        for (int k = 0; k < 5; k++) load_cap[k] = '0;
        for (int i = 0; i < 16; i++) consts[i] = '0;
    endtask

    task automatic send(input logic [319:0] s, input logic sel, output int acc);
        @(negedge clk);
        state_in   = s;
        rounds_sel = sel;
        in_valid   = 1'b1;
        @(posedge clk);
        @(negedge clk);
        acc      = cyc;
        in_valid = 1'b0;
    endtask

    task automatic wait_valid(input int limit, output int at, output bit ok);
        ok = 1'b0;
        at = 0;
        for (int i = 0; i < limit; i++) begin
            @(negedge clk);
            if (out_valid) begin
                ok = 1'b1;
                at = cyc;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b0;
        repeat (3) @(negedge clk);
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b expected 1", in_ready); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
        checks++; if ({perm_load, perm_start, perm_const, perm_unload} !== 4'b0) begin errors++; $display("FAIL reset_perm_ctl: got %b expected 0000", {perm_load, perm_start, perm_const, perm_unload}); end
        checks++; if (perm_data !== 5'b0) begin errors++; $display("FAIL reset_perm_data: got %b expected 00000", perm_data); end
        checks++; if (state_out !== 320'h0) begin errors++; $display("FAIL reset_state_out: got %h expected 0", state_out); end
`ifdef ASCON_SEQ_WATCHDOG_EN
        checks++; if (wd_err !== 1'b0) begin errors++; $display("FAIL reset_wd_err: got %b expected 0", wd_err); end
`endif
        rst = 1'b1;
        repeat (2) @(negedge clk);
        checks++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin errors++; $display("FAIL idle_after_reset: in_ready=%b out_valid=%b expected 1/0", in_ready, out_valid); end
    endtask

    task automatic test_pa();
        int acc, at;
        bit ok;
        clear_mon();
        core_en    = 1'b1;
        core_shift = R1;
        send(320'h0, 1'b0, acc);
        wait_valid(2000, at, ok);
        checks++; if (!ok) begin errors++; $display("FAIL pa_timeout: out_valid not seen within 2000 cycles"); end
        checks++; if (at - acc !== 64 + 12*71 + 64) begin errors++; $display("FAIL pa_latency: got %0d expected %0d edges after accept", at - acc, 64 + 12*71 + 64); end
        checks++; if (start_cnt !== 12) begin errors++; $display("FAIL pa_starts: got %0d expected 12", start_cnt); end
        checks++; if (consts[0] !== 8'hF0) begin errors++; $display("FAIL pa_rc0: got %h expected f0", consts[0]); end
        checks++; if (consts[1] !== 8'hE1) begin errors++; $display("FAIL pa_rc1: got %h expected e1", consts[1]); end
        checks++; if (consts[11] !== 8'h4B) begin errors++; $display("FAIL pa_rc11: got %h expected 4b", consts[11]); end
        checks++; if (load_cnt !== 64 || unload_cnt !== 64) begin errors++; $display("FAIL pa_load_unload_len: got %0d/%0d expected 64/64", load_cnt, unload_cnt); end
        checks++; if (state_out !== R1) begin errors++; $display("FAIL pa_state_out: got %h expected %h", state_out, R1); end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        checks++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin errors++; $display("FAIL pa_handshake: in_ready=%b out_valid=%b expected 1/0", in_ready, out_valid); end
    endtask

    task automatic test_pb();
        int acc, at;
        bit ok;
        clear_mon();
        core_shift = R2;
        send(R1, 1'b1, acc);
        wait_valid(1500, at, ok);
        checks++; if (!ok) begin errors++; $display("FAIL pb_timeout: out_valid not seen within 1500 cycles"); end
        checks++; if (at - acc !== 64 + 6*71 + 64) begin errors++; $display("FAIL pb_latency: got %0d expected %0d edges after accept", at - acc, 64 + 6*71 + 64); end
        checks++; if (start_cnt !== 6) begin errors++; $display("FAIL pb_starts: got %0d expected 6", start_cnt); end
        checks++; if (consts[0] !== 8'h96) begin errors++; $display("FAIL pb_rc_first: got %h expected 96", consts[0]); end
        checks++; if (consts[5] !== 8'h4B) begin errors++; $display("FAIL pb_rc_last: got %h expected 4b", consts[5]); end
        checks++; if (state_out !== R2) begin errors++; $display("FAIL pb_state_out: got %h expected %h", state_out, R2); end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    task automatic test_load_order();
        int acc, at;
        bit ok;
        logic [319:0] v;
        clear_mon();
        core_shift = R1;
        v = {64'h0, 64'h0, 64'h8000_0000_0000_0001, 64'h0, 64'h0};
        send(v, 1'b1, acc);
        wait_valid(1500, at, ok);
        checks++; if (load_cap[2] !== 64'h8000_0000_0000_0001) begin errors++; $display("FAIL load_x2: got %h expected 8000000000000001", load_cap[2]); end
        checks++; if ({load_cap[0], load_cap[1], load_cap[3], load_cap[4]} !== 256'h0) begin errors++; $display("FAIL load_other_lanes: got %h %h %h %h expected all 0", load_cap[0], load_cap[1], load_cap[3], load_cap[4]); end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        clear_mon();
        core_shift = R2;
        send(R1, 1'b1, acc);
        wait_valid(1500, at, ok);
        checks++; if (load_cap[0] !== 64'h0123_4567_89AB_CDEF) begin errors++; $display("FAIL load_x0: got %h expected 0123456789abcdef", load_cap[0]); end
        checks++; if (load_cap[4] !== 64'h0000_0000_CAFE_F00D) begin errors++; $display("FAIL load_x4: got %h expected 00000000cafef00d", load_cap[4]); end
        checks++; if (load_cap[1] !== 64'hFEDC_BA98_7654_3210) begin errors++; $display("FAIL load_x1: got %h expected fedcba9876543210", load_cap[1]); end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    task automatic test_backpressure();
        int acc, at;
        bit ok;
        clear_mon();
        core_shift = R2;
        send(R1, 1'b1, acc);
        wait_valid(1500, at, ok);
        checks++; if (!ok) begin errors++; $display("FAIL bp_timeout: out_valid not seen within 1500 cycles"); end
        in_valid = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            checks++;
            if (out_valid !== 1'b1 || in_ready !== 1'b0 || state_out !== R2) begin
                errors++;
                $display("FAIL bp_hold cycle %0d: out_valid=%b in_ready=%b state_out=%h expected 1/0/%h", i, out_valid, in_ready, state_out, R2);
            end
        end
        core_shift = R1;
        out_ready  = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        checks++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin errors++; $display("FAIL bp_release: in_ready=%b out_valid=%b expected 1/0", in_ready, out_valid); end
        @(negedge clk);
        in_valid = 1'b0;
        checks++; if (perm_load !== 1'b1 || in_ready !== 1'b0) begin errors++; $display("FAIL bp_reaccept: perm_load=%b in_ready=%b expected 1/0", perm_load, in_ready); end
        wait_valid(1500, at, ok);
        checks++; if (!ok || state_out !== R1) begin errors++; $display("FAIL bp_second_result: ok=%b state_out=%h expected %h", ok, state_out, R1); end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    task automatic test_reset_mid();
        int acc;
        int seen;
        int starts_at_reset;
        bit found;
        clear_mon();
        core_shift = R1;
        send(R2, 1'b0, acc);
        found = 1'b0;
        seen  = 0;
        for (int i = 0; i < 2000; i++) begin
            @(negedge clk);
            if (perm_start) seen++;
            if (seen == 6) begin
                found = 1'b1;
                break;
            end
        end
        checks++; if (!found) begin errors++; $display("FAIL rmid_round5_timeout: saw %0d starts, expected 6", seen); end
        repeat (10) @(negedge clk);
        rst = 1'b0;
        #1;
        checks++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin errors++; $display("FAIL rmid_async: in_ready=%b out_valid=%b expected 1/0", in_ready, out_valid); end
        @(negedge clk);
        checks++; if (perm_const !== 1'b0 || perm_start !== 1'b0 || state_out !== 320'h0) begin errors++; $display("FAIL rmid_cleared: perm_const=%b perm_start=%b state_out=%h expected 0/0/0", perm_const, perm_start, state_out); end
        rst = 1'b1;
        starts_at_reset = start_cnt;
        seen = 0;
        for (int i = 0; i < 1200; i++) begin
            @(negedge clk);
            if (out_valid || !in_ready) seen++;
        end
        checks++; if (seen !== 0) begin errors++; $display("FAIL rmid_stays_idle: got %0d non-idle cycles expected 0", seen); end
        checks++; if (start_cnt !== starts_at_reset) begin errors++; $display("FAIL rmid_no_starts: got %0d starts expected %0d", start_cnt, starts_at_reset); end
    endtask

`ifdef ASCON_SEQ_WATCHDOG_EN
    task automatic test_watchdog();
        int acc;
        int s;
        int e;
        bit found;
        clear_mon();
        core_en = 1'b0;
        send(R1, 1'b1, acc);
        s = 0;
        found = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (perm_start) begin
                s = cyc;
                found = 1'b1;
                break;
            end
        end
        checks++; if (!found) begin errors++; $display("FAIL wd_no_start: perm_start not seen within 200 cycles"); end
        e = 0;
        found = 1'b0;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if (wd_err) begin
                e = cyc;
                found = 1'b1;
                break;
            end
        end
        checks++; if (!found || e - s !== 257) begin errors++; $display("FAIL wd_timing: found=%b got %0d cycles expected 257", found, e - s); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL wd_idle: in_ready=%b expected 1", in_ready); end
        @(negedge clk);
        checks++; if (wd_err !== 1'b0) begin errors++; $display("FAIL wd_pulse_width: wd_err=%b expected 0", wd_err); end
        core_en = 1'b1;
    endtask
`endif

    initial begin
        test_reset();
        test_pa();
        test_pb();
        test_load_order();
        test_backpressure();
        test_reset_mid();
`ifdef ASCON_SEQ_WATCHDOG_EN
        test_watchdog();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1);
    end

endmodule
